dm_arbiter: RTL and testbench
=============================

// Module: dm_arbiter
// PURPOSE
//   Two-port access controller for the shared dm_4k data memory. Arbitrates between
//   m0 (CPU load/store path) and m1 (DMA/debug port), and converts each request's
//   byte address and size into the memory's word address, byte enables and ue flag.
//   Sequences every access IDLE->ACCESS->RESP, so each transaction takes 3 cycles.
//   Flags misaligned accesses and suppresses them before they reach memory.
// PARAMETERS
//   FIXED_PRIO  0  0 = round-robin; 1 = m0 always wins when both request
// PORTS
//   clk           in   1   clock; all state changes on posedge
//   rst_n         in   1   asynchronous, active-low reset
//   mX_req        in   1   request, X=0/1; sampled only in IDLE
//   mX_we         in   1   1 = store, 0 = load
//   mX_addr       in   12  byte address
//   mX_size       in   2   00 byte, 01 half, 10 word, 11 illegal
//   mX_sext       in   1   load sign-extend (1) / zero-extend (0)
//   mX_wdata      in   32  store data, right-justified (byte in [7:0], half in [15:0])
//   mX_gnt        out  1   1-cycle pulse in ACCESS: payload has been captured
//   mX_rvalid     out  1   1-cycle pulse in RESP: access done; rdata valid for loads
//   mX_err        out  1   1-cycle pulse in RESP instead of rvalid: misaligned/illegal
//   mX_rdata      out  32  = mem_dout in RESP for the granted port, else 0
//   busy          out  1   state != IDLE
//   mem_addr      out  10  word address to dm_4k (addr[11:2])
//   mem_be        out  4   byte enables to dm_4k
//   mem_din       out  32  store data to dm_4k (passed unshifted; memory aligns by be)
//   mem_wr        out  1   dm_4k write enable
//   mem_ue        out  1   dm_4k extension select (1 = sign-extend)
//   mem_dout      in   32  dm_4k read data, valid from the cycle after the ACCESS edge
// BEHAVIOUR
//   Reset (async): state=IDLE, rr_last=1 so m0 wins the first tie, capture regs=0.
//     All outputs are 0 while rst_n is low.
//   FSM
//     IDLE:   if any mX_req, pick a winner, capture its we/addr/size/sext/wdata and
//             record misalign; -> ACCESS. Otherwise stay in IDLE.
//     ACCESS: mX_gnt=1 for the winner; mem_* driven from the capture regs; -> RESP.
//     RESP:   winner gets rvalid=1 (or err=1); rdata=mem_dout; mem_wr=0; -> IDLE.
//   Arbitration
//     One requester: it wins. Both, FIXED_PRIO=1: m0 wins.
//     Both, FIXED_PRIO=0: the port != rr_last wins. rr_last updates on every grant.
//   Byte enables
//     Byte: 4'b0001<<addr[1:0]. Half: addr[1] ? 4'b1100 : 4'b0011. Word: 4'b1111.
//   Misalign
//     Half with addr[0]=1, word with addr[1:0]!=0, or size=11.
//     ACCESS then drives mem_be=0 and mem_wr=0, so memory is untouched.
//     RESP pulses err; rvalid stays 0 and rdata=0.
//   Memory drive outside ACCESS
//     mem_wr=0 and mem_be=0. mem_addr, mem_din and mem_ue hold their captured values.
//   Loads
//     mem_ue=sext; extension is done by dm_4k. rdata is not registered here.
//   Stores
//     rvalid in RESP means the write has completed; rdata is don't-care (mem_dout).
//   Requester handshake
//     Hold req and payload stable until gnt. req seen in ACCESS/RESP is ignored.
//     req still high when IDLE returns starts a new transaction.
//     Peak throughput is 1 access per 3 cycles.
//   Simultaneous req from the loser
//     It waits. Round-robin bounds the wait to one transaction (3 cycles).
//   Reset mid-transaction
//     Abort immediately. mem_wr drops asynchronously; no gnt, rvalid or err for the
//     aborted access.
// TESTING
//   1. m0 word store 0xDEADBEEF @0x010, then word load sext=0 -> gnt cycle 1,
//      rvalid cycle 2 both times; load rdata=0xDEADBEEF.
//   2. m1 byte store 0x7F @0x013, then byte loads @0x013 sext=1 and sext=0
//      -> mem_be=1000; both loads return 0x0000007F.
//      Then store 0x80 and repeat -> 0xFFFFFF80 (sext=1) and 0x00000080 (sext=0).
//   3. m0/m1 both hold req for 4 transactions, FIXED_PRIO=0 -> grants m0,m1,m0,m1.
//      With FIXED_PRIO=1 -> all grants go to m0 while m0 req stays high.
//   4. m0 half store @0x021 -> err=1 in RESP, rvalid=0, mem_wr never 1.
//      Word 0x020 still reads its prior value.
//   5. rst_n low during ACCESS of a store -> mem_wr=0 immediately, memory unchanged,
//      state=IDLE; next request is granted 1 cycle after rst_n rises.

Source files
------------

// File: rtl/dm_arbiter.sv
// dm_arbiter: two-port access controller in front of the dm_4k data memory.
// m0 (CPU load/store) and m1 (DMA/debug) compete for the memory; the winner's
// payload is captured in IDLE and replayed to the memory in ACCESS, then
// answered in RESP. Byte address/size become word address, byte enables and
// the sign-extend select. Misaligned or illegal accesses never reach memory.
module dm_arbiter #(
  parameter bit FIXED_PRIO = 1'b0
) (
  input  logic        clk,
  input  logic        rst_n,

  input  logic        m0_req,
  input  logic        m0_we,
  input  logic [11:0] m0_addr,
  input  logic [1:0]  m0_size,
  input  logic        m0_sext,
  input  logic [31:0] m0_wdata,
  output logic        m0_gnt,
  output logic        m0_rvalid,
  output logic        m0_err,
  output logic [31:0] m0_rdata,

  input  logic        m1_req,
  input  logic        m1_we,
  input  logic [11:0] m1_addr,
  input  logic [1:0]  m1_size,
  input  logic        m1_sext,
  input  logic [31:0] m1_wdata,
  output logic        m1_gnt,
  output logic        m1_rvalid,
  output logic        m1_err,
  output logic [31:0] m1_rdata,

  output logic        busy,

  output logic [9:0]  mem_addr,
  output logic [3:0]  mem_be,
  output logic [31:0] mem_din,
  output logic        mem_wr,
  output logic        mem_ue,
  input  logic [31:0] mem_dout
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    RESP   = 2'd2
  } state_t;

  state_t      state;

  // Arbitration history and captured transaction
  logic        rr_last;     // port granted most recently (1 = m1)
  logic        win;         // port owning the current transaction
  logic        cap_mis;     // current transaction is misaligned/illegal
  logic [9:0]  cap_waddr;
  logic        cap_sext;
  logic [31:0] cap_wdata;

  // Winner selection and its payload, valid only while in IDLE
  logic        pick;
  logic        sel_we;
  logic [11:0] sel_addr;
  logic [1:0]  sel_size;
  logic        sel_sext;
  logic [31:0] sel_wdata;
  logic        sel_mis;
  logic [3:0]  sel_be;

  // Byte enables for a legal access; misaligned cases are masked separately
  function automatic logic [3:0] be_of(input logic [1:0] a, input logic [1:0] size);
    logic [3:0] be;
    case (size)
      2'b00:   be = 4'b0001 << a;
      2'b01:   be = a[1] ? 4'b1100 : 4'b0011;
      2'b10:   be = 4'b1111;
      default: be = 4'b0000;
    endcase
    return be;
  endfunction

  // Half on an odd byte, word off a word boundary, or the reserved size code
  function automatic logic is_misaligned(input logic [1:0] a, input logic [1:0] size);
    logic bad;
    case (size)
      2'b00:   bad = 1'b0;
      2'b01:   bad = a[0];
      2'b10:   bad = (a != 2'b00);
      default: bad = 1'b1;
    endcase
    return bad;
  endfunction

  // Pick the winner: sole requester wins; on a tie fixed priority or round-robin
  always_comb begin
    pick = 1'b0;
    if (m0_req && m1_req) begin
      pick = FIXED_PRIO ? 1'b0 : ~rr_last;
    end else if (m1_req) begin
      pick = 1'b1;
    end
  end

  // Route the winning port's payload toward the capture registers
  always_comb begin
    sel_we    = m0_we;
    sel_addr  = m0_addr;
    sel_size  = m0_size;
    sel_sext  = m0_sext;
    sel_wdata = m0_wdata;
    if (pick) begin
      sel_we    = m1_we;
      sel_addr  = m1_addr;
      sel_size  = m1_size;
      sel_sext  = m1_sext;
      sel_wdata = m1_wdata;
    end
    sel_mis = is_misaligned(sel_addr[1:0], sel_size);
    sel_be  = be_of(sel_addr[1:0], sel_size);
  end

  // Transaction sequencer with registered handshake and memory strobes
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      rr_last   <= 1'b1;
      win       <= 1'b0;
      cap_mis   <= 1'b0;
      cap_waddr <= '0;
      cap_sext  <= 1'b0;
      cap_wdata <= '0;
      m0_gnt    <= 1'b0;
      m1_gnt    <= 1'b0;
      m0_rvalid <= 1'b0;
      m1_rvalid <= 1'b0;
      m0_err    <= 1'b0;
      m1_err    <= 1'b0;
      mem_be    <= '0;
      mem_wr    <= 1'b0;
    end else begin
      // Every handshake/strobe is a single-cycle pulse unless re-armed below
      m0_gnt    <= 1'b0;
      m1_gnt    <= 1'b0;
      m0_rvalid <= 1'b0;
      m1_rvalid <= 1'b0;
      m0_err    <= 1'b0;
      m1_err    <= 1'b0;
      mem_be    <= '0;
      mem_wr    <= 1'b0;
      case (state)
        IDLE: begin
          if (m0_req || m1_req) begin
            state     <= ACCESS;
            win       <= pick;
            rr_last   <= pick;
            cap_mis   <= sel_mis;
            cap_waddr <= sel_addr[11:2];
            cap_sext  <= sel_sext;
            cap_wdata <= sel_wdata;
            m0_gnt    <= ~pick;
            m1_gnt    <= pick;
            mem_be    <= sel_mis ? 4'b0000 : sel_be;
            mem_wr    <= sel_we & ~sel_mis;
          end
        end
        ACCESS: begin
          state     <= RESP;
          m0_rvalid <= ~win & ~cap_mis;
          m1_rvalid <=  win & ~cap_mis;
          m0_err    <= ~win &  cap_mis;
          m1_err    <=  win &  cap_mis;
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

  // Read data is passed straight through from memory during RESP only
  assign m0_rdata = (state == RESP && !win && !cap_mis) ? mem_dout : 32'h0;
  assign m1_rdata = (state == RESP &&  win && !cap_mis) ? mem_dout : 32'h0;

  assign busy     = (state != IDLE);
  assign mem_addr = cap_waddr;
  assign mem_din  = cap_wdata;
  assign mem_ue   = cap_sext;

endmodule

// File: tb/tb_dm_arbiter.sv
// Directed bench for dm_arbiter: one round-robin instance backed by a small
// dm_4k behavioural memory, plus a fixed-priority instance on the same inputs.
module tb_dm_arbiter;

  logic        clk;
  logic        rst_n;

  logic        m0_req, m0_we, m0_sext;
  logic [11:0] m0_addr;
  logic [1:0]  m0_size;
  logic [31:0] m0_wdata;
  logic        m1_req, m1_we, m1_sext;
  logic [11:0] m1_addr;
  logic [1:0]  m1_size;
  logic [31:0] m1_wdata;

  logic        m0_gnt, m0_rvalid, m0_err, m1_gnt, m1_rvalid, m1_err, busy;
  logic [31:0] m0_rdata, m1_rdata;
  logic [9:0]  mem_addr;
  logic [3:0]  mem_be;
  logic [31:0] mem_din, mem_dout;
  logic        mem_wr, mem_ue;

  logic        f_m0_gnt, f_m0_rvalid, f_m0_err, f_m1_gnt, f_m1_rvalid, f_m1_err, f_busy;
  logic [31:0] f_m0_rdata, f_m1_rdata;
  logic [9:0]  f_mem_addr;
  logic [3:0]  f_mem_be;
  logic [31:0] f_mem_din;
  logic        f_mem_wr, f_mem_ue;

  int checks   = 0;
  int failures = 0;

  dm_arbiter #(.FIXED_PRIO(1'b0)) dut (
    .clk(clk), .rst_n(rst_n),
    .m0_req(m0_req), .m0_we(m0_we), .m0_addr(m0_addr), .m0_size(m0_size),
    .m0_sext(m0_sext), .m0_wdata(m0_wdata), .m0_gnt(m0_gnt), .m0_rvalid(m0_rvalid),
    .m0_err(m0_err), .m0_rdata(m0_rdata),
    .m1_req(m1_req), .m1_we(m1_we), .m1_addr(m1_addr), .m1_size(m1_size),
    .m1_sext(m1_sext), .m1_wdata(m1_wdata), .m1_gnt(m1_gnt), .m1_rvalid(m1_rvalid),
    .m1_err(m1_err), .m1_rdata(m1_rdata),
    .busy(busy), .mem_addr(mem_addr), .mem_be(mem_be), .mem_din(mem_din),
    .mem_wr(mem_wr), .mem_ue(mem_ue), .mem_dout(mem_dout)
  );

  dm_arbiter #(.FIXED_PRIO(1'b1)) dut_fp (
    .clk(clk), .rst_n(rst_n),
    .m0_req(m0_req), .m0_we(m0_we), .m0_addr(m0_addr), .m0_size(m0_size),
    .m0_sext(m0_sext), .m0_wdata(m0_wdata), .m0_gnt(f_m0_gnt), .m0_rvalid(f_m0_rvalid),
    .m0_err(f_m0_err), .m0_rdata(f_m0_rdata),
    .m1_req(m1_req), .m1_we(m1_we), .m1_addr(m1_addr), .m1_size(m1_size),
    .m1_sext(m1_sext), .m1_wdata(m1_wdata), .m1_gnt(f_m1_gnt), .m1_rvalid(f_m1_rvalid),
    .m1_err(f_m1_err), .m1_rdata(f_m1_rdata),
    .busy(f_busy), .mem_addr(f_mem_addr), .mem_be(f_mem_be), .mem_din(f_mem_din),
    .mem_wr(f_mem_wr), .mem_ue(f_mem_ue), .mem_dout(32'h0)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // dm_4k stand-in: right-justified store data placed by be, registered read
  // with extension selected by ue.
  logic [31:0] mem [0:1023];
  initial mem_dout = 32'h0;
  always @(posedge clk) begin
    if (mem_wr) begin
      case (mem_be)
        4'b0001: mem[mem_addr][7:0]   <= mem_din[7:0];
        4'b0010: mem[mem_addr][15:8]  <= mem_din[7:0];
        4'b0100: mem[mem_addr][23:16] <= mem_din[7:0];
        4'b1000: mem[mem_addr][31:24] <= mem_din[7:0];
        4'b0011: mem[mem_addr][15:0]  <= mem_din[15:0];
        4'b1100: mem[mem_addr][31:16] <= mem_din[15:0];
        4'b1111: mem[mem_addr]        <= mem_din;
        default: ;
      endcase
    end
    if (mem_be != 4'b0000) begin
      case (mem_be)
        4'b0001: mem_dout <= mem_ue ? {{24{mem[mem_addr][7]}},  mem[mem_addr][7:0]}   : {24'h0, mem[mem_addr][7:0]};
        4'b0010: mem_dout <= mem_ue ? {{24{mem[mem_addr][15]}}, mem[mem_addr][15:8]}  : {24'h0, mem[mem_addr][15:8]};
        4'b0100: mem_dout <= mem_ue ? {{24{mem[mem_addr][23]}}, mem[mem_addr][23:16]} : {24'h0, mem[mem_addr][23:16]};
        4'b1000: mem_dout <= mem_ue ? {{24{mem[mem_addr][31]}}, mem[mem_addr][31:24]} : {24'h0, mem[mem_addr][31:24]};
        4'b0011: mem_dout <= mem_ue ? {{16{mem[mem_addr][15]}}, mem[mem_addr][15:0]}  : {16'h0, mem[mem_addr][15:0]};
        4'b1100: mem_dout <= mem_ue ? {{16{mem[mem_addr][31]}}, mem[mem_addr][31:16]} : {16'h0, mem[mem_addr][31:16]};
        default: mem_dout <= mem[mem_addr];
      endcase
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // One complete single-requester transaction with expectations for every phase
  task automatic xact(input string tag, input bit port, input bit we,
                      input logic [11:0] addr, input logic [1:0] size, input bit sext,
                      input logic [31:0] wdata, input bit bad, input logic [3:0] be,
                      input logic [31:0] rd);
    logic [31:0] who;
    who = port ? 32'd2 : 32'd1;
    if (!port) begin
      m0_req = 1'b1; m0_we = we; m0_addr = addr; m0_size = size; m0_sext = sext; m0_wdata = wdata;
    end else begin
      m1_req = 1'b1; m1_we = we; m1_addr = addr; m1_size = size; m1_sext = sext; m1_wdata = wdata;
    end
    step();
    chk({tag, "_gnt"},    {30'h0, m1_gnt, m0_gnt}, who);
    chk({tag, "_busy"},   {31'h0, busy}, 32'd1);
    chk({tag, "_be"},     {28'h0, mem_be}, {28'h0, be});
    chk({tag, "_wr"},     {31'h0, mem_wr}, {31'h0, we & ~bad});
    chk({tag, "_maddr"},  {22'h0, mem_addr}, {22'h0, addr[11:2]});
    if (!bad) chk({tag, "_ue"}, {31'h0, mem_ue}, {31'h0, sext});
    if (we && !bad) chk({tag, "_din"}, mem_din, wdata);
    m0_req = 1'b0;
    m1_req = 1'b0;
    step();
    chk({tag, "_rvalid"}, {30'h0, m1_rvalid, m0_rvalid}, bad ? 32'd0 : who);
    chk({tag, "_err"},    {30'h0, m1_err, m0_err},       bad ? who : 32'd0);
    chk({tag, "_wr_resp"}, {31'h0, mem_wr}, 32'd0);
    if (!we || bad) chk({tag, "_rdata"}, port ? m1_rdata : m0_rdata, bad ? 32'h0 : rd);
    chk({tag, "_other_rdata"}, port ? m0_rdata : m1_rdata, 32'h0);
    step();
    chk({tag, "_idle"}, {31'h0, busy}, 32'd0);
  endtask

  initial begin
    rst_n = 1'b0;
    m0_req = 1'b0; m0_we = 1'b0; m0_addr = 12'h0; m0_size = 2'b00; m0_sext = 1'b0; m0_wdata = 32'h0;
    m1_req = 1'b0; m1_we = 1'b0; m1_addr = 12'h0; m1_size = 2'b00; m1_sext = 1'b0; m1_wdata = 32'h0;
    repeat (3) step();

    // Outputs while held in reset
    chk("rst_ctrl", {25'h0, m0_gnt, m0_rvalid, m0_err, m1_gnt, m1_rvalid, m1_err, busy}, 32'h0);
    chk("rst_mem",  {17'h0, mem_addr, mem_be, mem_wr}, 32'h0);
    chk("rst_din",  mem_din, 32'h0);
    chk("rst_rdata", m0_rdata | m1_rdata, 32'h0);
    chk("rst_fp", {f_m0_gnt, f_m0_rvalid, f_m0_err, f_m1_gnt, f_m1_rvalid, f_m1_err, f_busy,
                   f_mem_wr, f_mem_ue, f_mem_be, f_mem_addr, 11'h0}
                   | f_m0_rdata | f_m1_rdata | f_mem_din, 32'h0);
    rst_n = 1'b1;
    step();
    chk("post_rst_idle", {31'h0, busy}, 32'd0);

    // 1: m0 word store then word load
    xact("t1_st", 1'b0, 1'b1, 12'h010, 2'b10, 1'b0, 32'hDEADBEEF, 1'b0, 4'b1111, 32'h0);
    xact("t1_ld", 1'b0, 1'b0, 12'h010, 2'b10, 1'b0, 32'h0,        1'b0, 4'b1111, 32'hDEADBEEF);

    // 2: m1 byte lane 3 with both extensions
    xact("t2_st7f", 1'b1, 1'b1, 12'h013, 2'b00, 1'b0, 32'h0000007F, 1'b0, 4'b1000, 32'h0);
    xact("t2_ld7f_s", 1'b1, 1'b0, 12'h013, 2'b00, 1'b1, 32'h0, 1'b0, 4'b1000, 32'h0000007F);
    xact("t2_ld7f_z", 1'b1, 1'b0, 12'h013, 2'b00, 1'b0, 32'h0, 1'b0, 4'b1000, 32'h0000007F);
    xact("t2_st80", 1'b1, 1'b1, 12'h013, 2'b00, 1'b0, 32'h00000080, 1'b0, 4'b1000, 32'h0);
    xact("t2_ld80_s", 1'b1, 1'b0, 12'h013, 2'b00, 1'b1, 32'h0, 1'b0, 4'b1000, 32'hFFFFFF80);
    xact("t2_ld80_z", 1'b1, 1'b0, 12'h013, 2'b00, 1'b0, 32'h0, 1'b0, 4'b1000, 32'h00000080);

    // 4: misaligned/illegal accesses leave memory untouched
    xact("t4_st_ok",  1'b0, 1'b1, 12'h020, 2'b10, 1'b0, 32'h11223344, 1'b0, 4'b1111, 32'h0);
    xact("t4_half21", 1'b0, 1'b1, 12'h021, 2'b01, 1'b0, 32'h0000BEEF, 1'b1, 4'b0000, 32'h0);
    xact("t4_word22", 1'b1, 1'b0, 12'h022, 2'b10, 1'b0, 32'h0,        1'b1, 4'b0000, 32'h0);
    xact("t4_size11", 1'b0, 1'b1, 12'h020, 2'b11, 1'b0, 32'hFFFFFFFF, 1'b1, 4'b0000, 32'h0);
    xact("t4_rd20",   1'b0, 1'b0, 12'h020, 2'b10, 1'b0, 32'h0,        1'b0, 4'b1111, 32'h11223344);
    xact("t4_half22", 1'b1, 1'b0, 12'h022, 2'b01, 1'b0, 32'h0,        1'b0, 4'b1100, 32'h00001122);

    // 3: both ports hold req for 4 transactions
    m0_req = 1'b1; m0_we = 1'b0; m0_addr = 12'h010; m0_size = 2'b10; m0_sext = 1'b0;
    m1_req = 1'b1; m1_we = 1'b0; m1_addr = 12'h020; m1_size = 2'b10; m1_sext = 1'b0;
    for (int k = 0; k < 4; k++) begin
      step();
      chk($sformatf("t3_rr_gnt%0d", k), {30'h0, m1_gnt, m0_gnt}, (k % 2) ? 32'd2 : 32'd1);
      chk($sformatf("t3_fp_gnt%0d", k), {30'h0, f_m1_gnt, f_m0_gnt}, 32'd1);
      if (k == 3) begin
        m0_req = 1'b0;
        m1_req = 1'b0;
      end
      step();
      chk($sformatf("t3_rr_rv%0d", k), {30'h0, m1_rvalid, m0_rvalid}, (k % 2) ? 32'd2 : 32'd1);
      if (k % 2) chk($sformatf("t3_rr_rd%0d", k), m1_rdata, 32'h11223344);
      step();
    end
    chk("t3_idle", {30'h0, f_busy, busy}, 32'd0);

    // 5: reset during ACCESS of a store aborts it
    m0_req = 1'b1; m0_we = 1'b1; m0_addr = 12'h020; m0_size = 2'b10; m0_sext = 1'b0;
    m0_wdata = 32'hCAFEF00D;
    step();
    chk("t5_wr_before", {31'h0, mem_wr}, 32'd1);
    m0_req = 1'b0;
    #1 rst_n = 1'b0;
    #1;
    chk("t5_wr_async", {31'h0, mem_wr}, 32'd0);
    chk("t5_abort_ctrl", {28'h0, busy, m0_gnt, mem_be != 4'b0000, f_mem_wr}, 32'd0);
    step();
    chk("t5_no_resp", {28'h0, m0_rvalid, m0_err, m1_rvalid, m1_err}, 32'd0);
    m0_req = 1'b1; m0_we = 1'b0; m0_addr = 12'h020; m0_size = 2'b10;
    rst_n = 1'b1;
    step();
    chk("t5_gnt_after_rst", {30'h0, m1_gnt, m0_gnt}, 32'd1);
    m0_req = 1'b0;
    step();
    chk("t5_rvalid", {31'h0, m0_rvalid}, 32'd1);
    chk("t5_mem_kept", m0_rdata, 32'h11223344);
    step();
    chk("t5_idle", {31'h0, busy}, 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
